// File: rtl/reg_write_ctrl.sv
// Register-file writeback controller: queues writeback requests in a small FIFO and can sweep
// all 16 registers to INIT_VALUE. Optional macro REG_WRITE_R0_ZERO_EN makes register 0 read-only zero.
module reg_write_ctrl #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] INIT_VALUE = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [3:0]               wb_dest,
    input  logic [15:0]              wb_data,
    input  logic                     init_start,
    output logic                     init_busy,
    output logic                     reg_write_en,
    output logic [3:0]               reg_write_dest,
    output logic [15:0]              reg_write_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic {S_IDLE, S_INIT} state_e;

    // Handshake: a request transfers on a rising edge where wb_valid and wb_ready are both 1;
    // wb_ready depends only on registered state (and rst), never on wb_valid.
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic [19:0]     mem_q [DEPTH];
    logic            en_q, en_d;
    logic [3:0]      dest_q, dest_d;
    logic [15:0]     data_q, data_d;
    logic            push, pop;
    logic [19:0]     head;

    assign wb_ready       = !rst && (state_q == S_IDLE) && (count_q != FULL);
    assign push           = wb_valid && wb_ready;
    assign head           = mem_q[rptr_q];
    assign init_busy      = (state_q == S_INIT);
    assign reg_write_en   = en_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    assign fifo_count     = count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
`ifdef REG_WRITE_R0_ZERO_EN
                    if (head[19:16] != 4'd0) begin
                        en_d   = 1'b1;
                        dest_d = head[19:16];
                        data_d = head[15:0];
                    end
`else
                    en_d   = 1'b1;
                    dest_d = head[19:16];
                    data_d = head[15:0];
`endif
                end
                if (init_start) begin
                    state_d = S_INIT;
                    cnt_d   = 4'd0;
                end
            end
            S_INIT: begin
                en_d   = 1'b1;
                dest_d = cnt_q;
`ifdef REG_WRITE_R0_ZERO_EN
                data_d = (cnt_q == 4'd0) ? 16'h0000 : INIT_VALUE;
`else
                data_d = INIT_VALUE;
`endif
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'hF) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            dest_q  <= 4'd0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {wb_dest, wb_data};
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based behavioural model.
module tb_reg_write_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [15:0] IV    = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst, wb_valid, wb_ready, init_start, init_busy, reg_write_en;
    logic [3:0]  wb_dest, reg_write_dest;
    logic [15:0] wb_data, reg_write_data;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    reg_write_ctrl #(.DEPTH(DEPTH), .INIT_VALUE(IV)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest(wb_dest), .wb_data(wb_data), .init_start(init_start),
        .init_busy(init_busy), .reg_write_en(reg_write_en),
        .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending requests, sweep progress, last visible write.
    logic [19:0] exp_q[$];
    int          sweep_idx = -1;  // -1 when no sweep is running
    logic        m_en = 1'b0;
    logic [3:0]  m_dest = 4'd0;
    logic [15:0] m_data = 16'h0;
    int          writes_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return (sweep_idx < 0) && (exp_q.size() < DEPTH);
    endfunction

    task automatic model_edge(input logic v, input logic [3:0] d, input logic [15:0] x,
                              input logic is, input logic r, input logic acc);
        logic [19:0] e;
        if (r) begin
            exp_q.delete();
            sweep_idx = -1;
            m_en = 1'b0; m_dest = 4'd0; m_data = 16'h0;
            return;
        end
        m_en = 1'b0;
        if (sweep_idx >= 0) begin
            m_en   = 1'b1;
            m_dest = sweep_idx[3:0];
            m_data = IV;
`ifdef REG_WRITE_R0_ZERO_EN
            if (sweep_idx == 0) m_data = 16'h0000;
`endif
            sweep_idx = (sweep_idx == 15) ? -1 : sweep_idx + 1;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_en = 1'b1;
`ifdef REG_WRITE_R0_ZERO_EN
                if (e[19:16] == 4'd0) m_en = 1'b0;
`endif
                if (m_en) begin
                    m_dest = e[19:16];
                    m_data = e[15:0];
                end
            end
            if (is) sweep_idx = 0;
        end
        if (acc && v) exp_q.push_back({d, x});
    endtask

    // One clock: drive inputs, check ready before the edge, then outputs after it.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [15:0] x,
                         input logic is, input logic r, output logic acc);
        logic exp_rdy;
        rst = r; wb_valid = v; wb_dest = d; wb_data = x; init_start = is;
        #1;
        exp_rdy = !r && model_ready();
        check("wb_ready", {31'd0, wb_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        model_edge(v, d, x, is, r, acc);
        #1;
        check("reg_write_en", {31'd0, reg_write_en}, {31'd0, m_en});
        check("reg_write_dest", {28'd0, reg_write_dest}, {28'd0, m_dest});
        check("reg_write_data", {16'd0, reg_write_data}, {16'd0, m_data});
        check("init_busy", {31'd0, init_busy}, {31'd0, (sweep_idx >= 0)});
        check("fifo_count", 32'(fifo_count), exp_q.size());
        if (reg_write_en) writes_seen++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic a;
        logic       v;
        logic [3:0] d;
        logic [15:0] x;
        rst = 1'b1; wb_valid = 1'b0; wb_dest = 4'd0; wb_data = 16'h0; init_start = 1'b0;
        @(posedge clk); #1;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, a);
        idle(1);

        // Single write, one-cycle latency
        cycle(1'b1, 4'd3, 16'hABCD, 1'b0, 1'b0, a);
        idle(3);

        // Push and pop on the same edge keep the count steady
        cycle(1'b1, 4'd9, 16'h1111, 1'b0, 1'b0, a);
        cycle(1'b1, 4'd5, 16'h2222, 1'b0, 1'b0, a);
        idle(3);

        // Register 0 followed by register 1
        cycle(1'b1, 4'd0, 16'h1234, 1'b0, 1'b0, a);
        cycle(1'b1, 4'd1, 16'h5678, 1'b0, 1'b0, a);
        idle(3);

        // Sweep started together with a request; a second pulse mid-sweep is ignored
        cycle(1'b1, 4'd7, 16'hBEEF, 1'b0, 1'b0, a);
        cycle(1'b1, 4'd6, 16'hCAFE, 1'b1, 1'b0, a);
        for (int i = 0; i < 18; i++) cycle(1'b1, 4'd2, 16'hDEAD, (i == 6), 1'b0, a);
        idle(4);

        // Reset in the middle of a sweep
        cycle(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, a);
        idle(7);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, a);
        idle(3);

        // Randomized traffic with held requests
        v = 1'b0; d = 4'd0; x = 16'h0;
        for (int i = 0; i < 1500; i++) begin
            logic is, r;
            if (!v || a) begin
                v = ($urandom_range(0, 99) < 60);
                d = 4'($urandom_range(0, 15));
                x = 16'($urandom);
            end
            is = ($urandom_range(0, 99) < 4);
            r  = ($urandom_range(0, 299) == 0);
            cycle(v, d, x, is, r, a);
            if (r) a = 1'b1;
        end
        idle(25);

        check("writes_observed_nonzero", {31'd0, (writes_seen > 0)}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
